ipsxe_floating_point_axis_fifo_ctrl_v1_0: RTL and testbench

AXI-stream FIFO controller that sequences the dual-port SRAM model as a first-word-fall-through buffer between floating-point pipeline stages. It owns the write and read pointers, the occupancy count and the valid/ready handshakes on both sides, and drives the SRAM's write and read ports directly. The block is placed wherever an operator core needs elastic buffering against downstream back-pressure.

---
 rtl/ipsxe_floating_point_fifo_pkg.sv | 23 ++
 rtl/ipsxe_floating_point_sram_dualports_v1_0.sv | 38 +++
 rtl/ipsxe_floating_point_axis_fifo_ctrl_v1_0.sv | 104 ++++++++++
 tb/tb_ipsxe_floating_point_axis_fifo_ctrl_v1_0.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ipsxe_floating_point_fifo_pkg.sv
// Shared helpers for the floating-point AXI-stream FIFO: width math, pointer wrap, reset values.
// Optional almost-full output is enabled with IPSXE_FLOATING_POINT_FIFO_AFULL_EN.
package ipsxe_floating_point_fifo_pkg;

    localparam int unsigned RST_PTR   = 0;
    localparam int unsigned RST_COUNT = 0;
    localparam logic        RST_AFULL = 1'b0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

    // Depth need not be a power of two, so wrap is an explicit compare.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_sram_dualports_v1_0.sv
// Simple dual-port SRAM model: synchronous write port, asynchronous read port.
// Part of the FIFO bundle built with or without IPSXE_FLOATING_POINT_FIFO_AFULL_EN.
module ipsxe_floating_point_sram_dualports_v1_0
    import ipsxe_floating_point_fifo_pkg::*;
#(
    parameter int MEM_WIDTH  = 32,
    parameter int MEM_DEPTH  = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_wa,
    input  logic [MEM_WIDTH-1:0]  i_d,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_ra,
    output logic [MEM_WIDTH-1:0]  o_q
);

    localparam int IDX_W = clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [MEM_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];
    logic                 w_wa_ok;
    logic                 w_ra_ok;

    // Out-of-range addresses are ignored on write and read back as zero.
    assign w_wa_ok = ({1'b0, i_wa} < DEPTH_C);
    assign w_ra_ok = ({1'b0, i_ra} < DEPTH_C);

    always_ff @(posedge i_clk) begin
        if (i_we && w_wa_ok) begin
            r_mem[i_wa[IDX_W-1:0]] <= i_d;
        end
    end

    assign o_q = (i_re && w_ra_ok) ? r_mem[i_ra[IDX_W-1:0]] : '0;

endmodule

// File: rtl/ipsxe_floating_point_axis_fifo_ctrl_v1_0.sv
// First-word-fall-through AXI-stream FIFO controller around the dual-port SRAM model.
// Define IPSXE_FLOATING_POINT_FIFO_AFULL_EN to add the registered o_afull output.
module ipsxe_floating_point_axis_fifo_ctrl_v1_0
    import ipsxe_floating_point_fifo_pkg::*;
#(
    parameter int MEM_WIDTH  = 32,
    parameter int MEM_DEPTH  = 4,
    parameter int ADDR_WIDTH = 8
`ifdef IPSXE_FLOATING_POINT_FIFO_AFULL_EN
    ,
    parameter int AFULL_THRESH = MEM_DEPTH - 1
`endif
) (
    input  logic                  i_aclk,
    input  logic                  i_areset,
    input  logic                  i_flush,
    input  logic [MEM_WIDTH-1:0]  i_axis_tdata,
    input  logic                  i_axis_tvalid,
    output logic                  o_axis_tready,
    output logic [MEM_WIDTH-1:0]  o_axis_tdata,
    output logic                  o_axis_tvalid,
    input  logic                  i_axis_tready,
    output logic [ADDR_WIDTH:0]   o_count
`ifdef IPSXE_FLOATING_POINT_FIFO_AFULL_EN
    ,
    output logic                  o_afull
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  w_push;
    logic                  w_pop;

    // Handshake: a beat transfers on a side only in a cycle where valid and ready are both high.
    // Both ready/valid we drive come straight from the registered count.
    assign o_axis_tvalid = (r_count != '0);
    assign o_axis_tready = (r_count != DEPTH_C);
    assign w_push        = i_axis_tvalid && o_axis_tready;
    assign w_pop         = o_axis_tvalid && i_axis_tready;
    assign o_count       = r_count;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + ONE_C;
            2'b01:   w_count_nxt = r_count - ONE_C;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset || i_flush) begin
            r_wr_ptr <= ADDR_WIDTH'(RST_PTR);
            r_rd_ptr <= ADDR_WIDTH'(RST_PTR);
            r_count  <= (ADDR_WIDTH+1)'(RST_COUNT);
        end else begin
            if (w_push) begin
                r_wr_ptr <= ADDR_WIDTH'(ptr_inc(32'(r_wr_ptr), MEM_DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= ADDR_WIDTH'(ptr_inc(32'(r_rd_ptr), MEM_DEPTH));
            end
            r_count <= w_count_nxt;
        end
    end

`ifdef IPSXE_FLOATING_POINT_FIFO_AFULL_EN
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);

    logic r_afull;

    always_ff @(posedge i_aclk) begin
        if (i_areset || i_flush) begin
            r_afull <= RST_AFULL;
        end else begin
            r_afull <= (w_count_nxt >= AFULL_C);
        end
    end

    assign o_afull = r_afull;
`endif

    // Read port is always enabled at rd_ptr, giving fall-through output data.
    ipsxe_floating_point_sram_dualports_v1_0 #(
        .MEM_WIDTH  (MEM_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .i_clk (i_aclk),
        .i_we  (w_push),
        .i_wa  (r_wr_ptr),
        .i_d   (i_axis_tdata),
        .i_re  (1'b1),
        .i_ra  (r_rd_ptr),
        .o_q   (o_axis_tdata)
    );

endmodule

// File: tb/tb_ipsxe_floating_point_axis_fifo_ctrl_v1_0.sv
// Bench for the AXI-stream FIFO controller: vector table, corner sequences, random vs queue model.
// Also checks o_afull when built with IPSXE_FLOATING_POINT_FIFO_AFULL_EN.
module tb_ipsxe_floating_point_axis_fifo_ctrl_v1_0;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int THR   = DEPTH - 1;

    logic          clk = 1'b0;
    logic          areset;
    logic          flush;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   count;
`ifdef IPSXE_FLOATING_POINT_FIFO_AFULL_EN
    logic          afull;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: the FIFO contents, oldest first.
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic          r;
        logic [AW:0]   e_cnt;
        logic          e_tv;
        logic          e_tr;
        logic          chk_d;
        logic [W-1:0]  e_d;
    } vec_t;

    vec_t vec[11];

    always #5 clk = ~clk;

    ipsxe_floating_point_axis_fifo_ctrl_v1_0 #(
        .MEM_WIDTH  (W),
        .MEM_DEPTH  (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_aclk        (clk),
        .i_areset      (areset),
        .i_flush       (flush),
        .i_axis_tdata  (in_data),
        .i_axis_tvalid (in_valid),
        .o_axis_tready (in_ready),
        .o_axis_tdata  (out_data),
        .o_axis_tvalid (out_valid),
        .i_axis_tready (out_ready),
        .o_count       (count)
`ifdef IPSXE_FLOATING_POINT_FIFO_AFULL_EN
        ,
        .o_afull       (afull)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; model updated from the rules, then outputs compared.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r,
                        input logic fl, input logic rs, input string tag);
        int sz;
        sz       = exp_q.size();
        in_valid = v;
        in_data  = d;
        out_ready = r;
        flush    = fl;
        areset   = rs;
        @(posedge clk);
        #1;
        if (rs || fl) begin
            exp_q.delete();
        end else begin
            if (r && sz > 0) void'(exp_q.pop_front());
            if (v && sz < DEPTH) exp_q.push_back(d);
        end
        chk({tag, ".count"}, 64'(count), 64'(exp_q.size()));
        chk({tag, ".tvalid"}, 64'(out_valid), 64'(exp_q.size() != 0));
        chk({tag, ".tready"}, 64'(in_ready), 64'(exp_q.size() != DEPTH));
        if (exp_q.size() != 0) chk({tag, ".tdata"}, 64'(out_data), 64'(exp_q[0]));
`ifdef IPSXE_FLOATING_POINT_FIFO_AFULL_EN
        chk({tag, ".afull"}, 64'(afull), 64'(exp_q.size() >= THR));
`endif
    endtask

    initial begin
        areset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        vec[0]  = '{1'b1, 32'h3F800000, 1'b0, 9'd1, 1'b1, 1'b1, 1'b1, 32'h3F800000};
        vec[1]  = '{1'b1, 32'h40000000, 1'b0, 9'd2, 1'b1, 1'b1, 1'b1, 32'h3F800000};
        vec[2]  = '{1'b1, 32'h40400000, 1'b0, 9'd3, 1'b1, 1'b1, 1'b1, 32'h3F800000};
        vec[3]  = '{1'b1, 32'h40800000, 1'b0, 9'd4, 1'b1, 1'b0, 1'b1, 32'h3F800000};
        vec[4]  = '{1'b1, 32'hDEADBEEF, 1'b0, 9'd4, 1'b1, 1'b0, 1'b1, 32'h3F800000};
        vec[5]  = '{1'b0, 32'h0,        1'b1, 9'd3, 1'b1, 1'b1, 1'b1, 32'h40000000};
        vec[6]  = '{1'b0, 32'h0,        1'b1, 9'd2, 1'b1, 1'b1, 1'b1, 32'h40400000};
        vec[7]  = '{1'b0, 32'h0,        1'b1, 9'd1, 1'b1, 1'b1, 1'b1, 32'h40800000};
        vec[8]  = '{1'b0, 32'h0,        1'b1, 9'd0, 1'b0, 1'b1, 1'b0, 32'h0};
        vec[9]  = '{1'b1, 32'hC0000000, 1'b1, 9'd1, 1'b1, 1'b1, 1'b1, 32'hC0000000};
        vec[10] = '{1'b0, 32'h0,        1'b1, 9'd0, 1'b0, 1'b1, 1'b0, 32'h0};

        step(1'b0, '0, 1'b0, 1'b0, 1'b1, "reset0");
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, "reset1");

        // Fill/drain and single-word latency from the vector table.
        for (int i = 0; i < 11; i++) begin
            areset = 1'b0; flush = 1'b0;
            in_valid = vec[i].v; in_data = vec[i].d; out_ready = vec[i].r;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.count", i), 64'(count), 64'(vec[i].e_cnt));
            chk($sformatf("vec%0d.tvalid", i), 64'(out_valid), 64'(vec[i].e_tv));
            chk($sformatf("vec%0d.tready", i), 64'(in_ready), 64'(vec[i].e_tr));
            if (vec[i].chk_d) chk($sformatf("vec%0d.tdata", i), 64'(out_data), 64'(vec[i].e_d));
        end
        exp_q.delete();

        // Continuous stream of 10 words; pointers wrap twice at depth 4.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, W'(k), 1'b1, 1'b0, 1'b0, $sformatf("wrap%0d", k));
            chk($sformatf("wrap%0d.data", k), 64'(out_data), 64'(k));
            chk($sformatf("wrap%0d.cnt1", k), 64'(count), 64'd1);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, "wrap_drain");

        // Full with simultaneous pop: pop only, then push+pop at count 3.
        for (int k = 0; k < 4; k++) step(1'b1, 32'hA0 + W'(k), 1'b0, 1'b0, 1'b0, "fill");
        step(1'b1, 32'hB0, 1'b1, 1'b0, 1'b0, "full_pop");
        chk("full_pop.cnt3", 64'(count), 64'd3);
        chk("full_pop.head", 64'(out_data), 64'hA1);
        step(1'b1, 32'hB1, 1'b1, 1'b0, 1'b0, "full_pushpop");
        chk("full_pushpop.cnt3", 64'(count), 64'd3);

        // Flush at count 2, then areset at count 2; the next push must not show stale data.
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b0, "clear_pre");
            step(1'b1, 32'h55555555, 1'b0, 1'b0, 1'b0, "two_a");
            step(1'b1, 32'h66666666, 1'b0, 1'b0, 1'b0, "two_b");
            step(1'b1, 32'h77777777, 1'b1, (pass == 0), (pass == 1), "clear");
            chk("clear.cnt0", 64'(count), 64'd0);
            chk("clear.tready", 64'(in_ready), 64'd1);
            step(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, "after_clear");
            chk("after_clear.data", 64'(out_data), 64'h11111111);
        end

        // Almost-full crossing: up to 3 then one pop.
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, "af_clear");
        for (int k = 0; k < 3; k++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0, "af_fill");
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, "af_pop");

        // Randomized traffic with occasional flush.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 49) == 0), 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
